res_wb_pack: RTL and testbench

RES_WB_PACK -- requirements
Module: res_wb_pack

---
 rtl/res_wb_pack_if.sv | 34 +++
 rtl/res_wb_pack.sv | 142 ++++++++++++++
 tb/tb_res_wb_pack.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/res_wb_pack_if.sv
// Handshake bundle for res_wb_pack: residual-add input stream plus the write-request port.
// Beat geometry comes from the CNN build defines; the fallbacks match the reference build.
`ifndef Tout
`define Tout 32
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 8
`endif

interface res_wb_pack_if #(
  parameter int ADDR_W = 32
);
  localparam int DATA_W = `Tout * `MAX_DAT_DW;

  logic              dat_in_vld;
  logic              dat_in_rdy;
  logic [DATA_W-1:0] dat_in_pd;
  logic              wr_vld;
  logic              wr_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;

  // The environment side: drives beats in and accepts writes out.
  modport master (
    output dat_in_vld, dat_in_pd, wr_rdy,
    input  dat_in_rdy, wr_vld, wr_addr, wr_data, wr_last
  );

  modport slave (
    input  dat_in_vld, dat_in_pd, wr_rdy,
    output dat_in_rdy, wr_vld, wr_addr, wr_data, wr_last
  );
endinterface

// File: rtl/res_wb_pack.sv
// Packs residual-add result beats into addressed write requests for one 2-D tile.
// Optional zero-lane statistic enabled by defining RESWB_ZERO_CNT_EN.
`ifndef Tout
`define Tout 32
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 8
`endif

module res_wb_pack #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_w,
  input  logic [LEN_W-1:0]  cfg_h,
  input  logic [ADDR_W-1:0] cfg_line_stride,
  output logic              busy,
  output logic              done,
  output logic [31:0]       zero_cnt,
  res_wb_pack_if.slave      bus
);
  localparam int LANES      = `Tout;
  localparam int LANE_W     = `MAX_DAT_DW;
  localparam int DATA_W     = LANES * LANE_W;
  localparam int BEAT_BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  w_q, h_q, x, y;
  logic [ADDR_W-1:0] stride_q, line_base, cur_addr;

  logic [ADDR_W-1:0] buf_addr [2];
  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_last;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic in_acc, pop, x_end, last_flag;

  // Readiness depends only on registered state, never on wr_rdy.
  assign bus.dat_in_rdy = (state == RUN) && (count != 2'd2);
  assign in_acc         = bus.dat_in_vld && bus.dat_in_rdy;
  assign pop            = bus.wr_vld && bus.wr_rdy;
  assign x_end          = (x == w_q - LEN_W'(1));
  assign last_flag      = x_end && (y == h_q - LEN_W'(1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign bus.wr_vld  = (count != 2'd0);
  assign bus.wr_addr = bus.wr_vld ? buf_addr[rd_ptr] : '0;
  assign bus.wr_data = bus.wr_vld ? buf_data[rd_ptr] : '0;
  assign bus.wr_last = bus.wr_vld && buf_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      stride_q  <= '0;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      cur_addr  <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          w_q       <= cfg_w;
          h_q       <= cfg_h;
          stride_q  <= cfg_line_stride;
          line_base <= cfg_base_addr;
          cur_addr  <= cfg_base_addr;
          x         <= '0;
          y         <= '0;
          state     <= (cfg_w == '0 || cfg_h == '0) ? DONE : RUN;
        end
        RUN: if (in_acc) begin
          if (x_end) begin
            x         <= '0;
            y         <= y + LEN_W'(1);
            line_base <= line_base + stride_q;
            cur_addr  <= line_base + stride_q;
          end else begin
            x        <= x + LEN_W'(1);
            cur_addr <= cur_addr + ADDR_W'(BEAT_BYTES);
          end
          if (last_flag) state <= DRAIN;
        end
        DRAIN: if (pop && bus.wr_last) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (in_acc) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      count <= count + 2'(in_acc) - 2'(pop);
    end
  end

  // NOTE: buffer storage is deliberately not reset; emptiness is tracked by count and
  // the outputs are masked to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      buf_addr[wr_ptr] <= cur_addr;
      buf_data[wr_ptr] <= bus.dat_in_pd;
      buf_last[wr_ptr] <= last_flag;
    end
  end

`ifdef RESWB_ZERO_CNT_EN
  localparam int ZW = $clog2(LANES + 1);

  logic [ZW-1:0] zero_lanes;
  logic [32:0]   zero_sum;

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.dat_in_pd[i*LANE_W +: LANE_W] == '0) zero_lanes = zero_lanes + ZW'(1);
    end
  end

  assign zero_sum = {1'b0, zero_cnt} + 33'(zero_lanes);

  always_ff @(posedge clk) begin
    if (rst)                         zero_cnt <= '0;
    else if (state == IDLE && start) zero_cnt <= '0;
    else if (in_acc)                 zero_cnt <= zero_sum[32] ? 32'hFFFF_FFFF : zero_sum[31:0];
  end
`else
  assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_res_wb_pack.sv
// Directed bench for res_wb_pack: tile addressing, stalls, empty tile, mid-tile reset, wrap.
`ifndef Tout
`define Tout 32
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 8
`endif

module tb_res_wb_pack;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int LANES  = `Tout;
  localparam int LW     = `MAX_DAT_DW;
  localparam int DATA_W = LANES * LW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [LEN_W-1:0]  cfg_w;
  logic [LEN_W-1:0]  cfg_h;
  logic [ADDR_W-1:0] cfg_line_stride;
  logic              busy;
  logic              done;
  logic [31:0]       zero_cnt;

  res_wb_pack_if #(.ADDR_W(ADDR_W)) bus ();

  res_wb_pack #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_w           (cfg_w),
    .cfg_h           (cfg_h),
    .cfg_line_stride (cfg_line_stride),
    .busy            (busy),
    .done            (done),
    .zero_cnt        (zero_cnt),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] tile_data [6];
  logic [ADDR_W-1:0] exp_addr  [6];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch a tile and service it; rdy_mode 1 toggles wr_rdy 1-0-0-1.
  task automatic run_tile(input logic [ADDR_W-1:0] base, input int w, input int h,
                          input logic [ADDR_W-1:0] stride, input int rdy_mode,
                          input bit poke_start, input string tag);
    int n_beats, n_in, n_pop, last_pop_cyc;
    bit stalled, got_done;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic              h_last;
    n_beats = w * h; n_in = 0; n_pop = 0; last_pop_cyc = -100;
    stalled = 1'b0; got_done = 1'b0;
    h_addr = '0; h_data = '0; h_last = 1'b0;

    cfg_base_addr = base; cfg_w = LEN_W'(w); cfg_h = LEN_W'(h); cfg_line_stride = stride;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      bus.dat_in_vld = (n_in < n_beats);
      bus.dat_in_pd  = (n_in < n_beats) ? tile_data[n_in] : '0;
      bus.wr_rdy     = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (poke_start && cyc == 2) begin start = 1'b1; cfg_base_addr = 32'hDEAD_0000; end
      if (poke_start && cyc == 3) begin start = 1'b0; cfg_base_addr = base; end

      @(negedge clk);
      if (stalled) begin
        check({tag, " hold_vld"},  bus.wr_vld,  1'b1);
        check({tag, " hold_addr"}, bus.wr_addr, h_addr);
        check({tag, " hold_data"}, bus.wr_data, h_data);
        check({tag, " hold_last"}, bus.wr_last, h_last);
      end
      if (n_in - n_pop == 2) check({tag, " rdy_full"}, bus.dat_in_rdy, 1'b0);
      if (bus.wr_vld && bus.wr_rdy) begin
        if (n_pop < n_beats) begin
          check({tag, " addr"}, bus.wr_addr, exp_addr[n_pop]);
          check({tag, " data"}, bus.wr_data, tile_data[n_pop]);
          check({tag, " last"}, bus.wr_last, (n_pop == n_beats - 1));
          if (n_pop == n_beats - 1) last_pop_cyc = cyc;
        end else begin
          check({tag, " extra_write"}, 1'b1, 1'b0);
        end
        n_pop++;
      end
      stalled = bus.wr_vld && !bus.wr_rdy;
      h_addr = bus.wr_addr; h_data = bus.wr_data; h_last = bus.wr_last;
      if (bus.dat_in_vld && bus.dat_in_rdy) n_in++;
      if (done) begin
        got_done = 1'b1;
        check({tag, " done_lat"}, 32'(cyc), 32'(last_pop_cyc + 1));
        check({tag, " n_writes"}, 32'(n_pop), 32'(n_beats));
      end
      @(posedge clk); #1;
    end
    check({tag, " done_seen"}, got_done, 1'b1);
    bus.dat_in_vld = 1'b0;
    bus.wr_rdy     = 1'b1;
    @(negedge clk);
    check({tag, " busy_after"}, busy, 1'b0);
    check({tag, " done_after"}, done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_base_addr = '0; cfg_w = '0; cfg_h = '0; cfg_line_stride = '0;
    bus.dat_in_vld = 1'b0; bus.dat_in_pd = '0; bus.wr_rdy = 1'b1;

    // Beat 0: all lanes zero; beat 1: lanes 0..4 zero; the rest nonzero.
    for (int i = 0; i < 6; i++) begin
      for (int l = 0; l < LANES; l++) begin
        if (i == 0)      tile_data[i][l*LW +: LW] = '0;
        else if (i == 1) tile_data[i][l*LW +: LW] = (l < 5) ? LW'(0) : LW'(8'hA5);
        else             tile_data[i][l*LW +: LW] = LW'(8'h10 + i);
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy",     busy,           1'b0);
    check("rst done",     done,           1'b0);
    check("rst in_rdy",   bus.dat_in_rdy, 1'b0);
    check("rst wr_vld",   bus.wr_vld,     1'b0);
    check("rst wr_last",  bus.wr_last,    1'b0);
    check("rst wr_addr",  bus.wr_addr,    '0);
    check("rst wr_data",  bus.wr_data,    '0);
    check("rst zero_cnt", zero_cnt,       '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Beats offered while idle are held off.
    bus.dat_in_vld = 1'b1; bus.dat_in_pd = tile_data[2];
    @(negedge clk);
    check("idle in_rdy", bus.dat_in_rdy, 1'b0);
    @(posedge clk); #1;
    bus.dat_in_vld = 1'b0;

    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1020; exp_addr[2] = 32'h1040;
    exp_addr[3] = 32'h1100; exp_addr[4] = 32'h1120; exp_addr[5] = 32'h1140;
    run_tile(32'h1000, 3, 2, 32'h100, 0, 1'b0, "tile");
`ifdef RESWB_ZERO_CNT_EN
    check("zero_cnt", zero_cnt, 32'd37);
`else
    check("zero_cnt", zero_cnt, 32'd0);
`endif

    run_tile(32'h1000, 3, 2, 32'h100, 1, 1'b1, "stall");

    // Empty tile: done one cycle after start, busy for that cycle only.
    cfg_base_addr = 32'h5000; cfg_w = '0; cfg_h = 16'd5; cfg_line_stride = 32'h100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("empty busy",   busy,       1'b1);
    check("empty done",   done,       1'b1);
    check("empty wr_vld", bus.wr_vld, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("empty busy_after", busy,       1'b0);
    check("empty done_after", done,       1'b0);
    check("empty wr_vld2",    bus.wr_vld, 1'b0);
    @(posedge clk); #1;

    // Reset mid-tile with two beats held in the buffer, start coincident with reset.
    cfg_base_addr = 32'h3000; cfg_w = 16'd3; cfg_h = 16'd2; cfg_line_stride = 32'h100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.wr_rdy = 1'b0;
    bus.dat_in_vld = 1'b1; bus.dat_in_pd = tile_data[2];
    @(posedge clk); #1;
    bus.dat_in_pd = tile_data[3];
    @(posedge clk); #1;
    bus.dat_in_vld = 1'b0;
    @(negedge clk);
    check("mid wr_vld",  bus.wr_vld,     1'b1);
    check("mid in_rdy",  bus.dat_in_rdy, 1'b0);
    check("mid wr_addr", bus.wr_addr,    32'h3000);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; cfg_base_addr = 32'h4000; cfg_w = 16'd1; cfg_h = 16'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("mrst busy",     busy,           1'b0);
    check("mrst done",     done,           1'b0);
    check("mrst in_rdy",   bus.dat_in_rdy, 1'b0);
    check("mrst wr_vld",   bus.wr_vld,     1'b0);
    check("mrst wr_last",  bus.wr_last,    1'b0);
    check("mrst wr_addr",  bus.wr_addr,    '0);
    check("mrst wr_data",  bus.wr_data,    '0);
    check("mrst zero_cnt", zero_cnt,       '0);
    @(posedge clk); #1;
    bus.wr_rdy = 1'b1;

    exp_addr[0] = 32'h2000;
    run_tile(32'h2000, 1, 1, 32'h0, 0, 1'b0, "after_rst");

    exp_addr[0] = 32'hFFFF_FFE0; exp_addr[1] = 32'h0000_0000;
    run_tile(32'hFFFF_FFE0, 2, 1, 32'h40, 0, 1'b0, "wrap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
